uart_rx_gen2: RTL and testbench
===============================

UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, width of PRESCALE port.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, pre-synchronised externally.
REQ-006 SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-007 SHALL have port PAR_TYP  input  1  0 even, 1 odd.
REQ-008 SHALL have port STOP2  input  1  two stop bits when 1, else one.
REQ-009 SHALL have port PRESCALE  input  PRESCALE_WIDTH  CLK cycles per bit (legal 8, 16, 32).
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  last good frame, LSB first on line.
REQ-011 SHALL have port DATA_VALID  output  1  one-cycle pulse, good frame.
REQ-012 SHALL have port PAR_ERR  output  1  one-cycle pulse, parity mismatch.
REQ-013 SHALL have port STOP_ERR  output  1  one-cycle pulse, a stop bit sampled 0.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, STOP_2.
REQ-015 SHALL use an edge counter 0..PRESCALE-1 per bit and a bit counter 0..DATA_WIDTH-1, both cleared on entering START.
REQ-016 SHALL sample each bit by 2-of-3 majority of RX_IN at edge counts PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1; the result is valid from edge count PRESCALE/2+2.
REQ-017 SHALL leave IDLE for START on the first cycle RX_IN=0.
REQ-018 SHALL latch PAR_EN, PAR_TYP, STOP2 and PRESCALE on the IDLE->START transition; input changes during a frame are ignored.
REQ-019 SHALL treat a START majority sample of 1 as a glitch: return to IDLE at edge count PRESCALE-1 with no output pulse.
REQ-020 SHALL shift DATA samples LSB first; DATA->PARITY (latched PAR_EN=1) or DATA->STOP (PAR_EN=0) after bit DATA_WIDTH-1 at edge count PRESCALE-1.
REQ-021 SHALL compute parity as XOR of data bits (XNOR for odd); a mismatch sets an internal error flag.
REQ-022 SHALL go STOP->STOP_2 when latched STOP2=1, else STOP->IDLE, at edge count PRESCALE-1; STOP_2->IDLE likewise.
REQ-023 SHALL evaluate the frame at edge count PRESCALE-1 of the final stop bit: if no error, update P_DATA and pulse DATA_VALID in the same cycle; otherwise pulse PAR_ERR and/or STOP_ERR (both may assert together), with P_DATA unchanged and DATA_VALID low.
REQ-024 SHALL continue to the stop bit(s) after a parity error; a stop error in STOP (two-stop mode) still completes STOP_2 before reporting.
REQ-025 SHALL accept a back-to-back frame: a start bit beginning the cycle after the final stop bit's end is received.
REQ-026 SHALL hold P_DATA stable between DATA_VALID pulses.

Reset
REQ-027 SHALL, on RST=1 at any time including mid-frame, force IDLE, clear all counters, shift register and error flags, and drive P_DATA=0, DATA_VALID=0, PAR_ERR=0, STOP_ERR=0 immediately.
REQ-028 SHALL resume operation on the first rising CLK edge after RST deasserts; any frame in progress is discarded.

Configuration
REQ-029 SHALL, when macro UART_RX_BREAK_DETECT_EN is defined, add port BREAK  output  1  one-cycle pulse, reset 0, plus state BRK_WAIT.
REQ-030 With UART_RX_BREAK_DETECT_EN: a frame whose data bits, parity bit (if enabled) and first stop bit all sample 0 SHALL pulse BREAK together with STOP_ERR, suppress PAR_ERR, then remain in BRK_WAIT until RX_IN=1, then go IDLE.
REQ-031 Without UART_RX_BREAK_DETECT_EN: no BREAK port or BRK_WAIT state; an all-zero frame SHALL report STOP_ERR only, and the FSM returns to IDLE.

Verification
REQ-032 PRESCALE=8, PAR_EN=0, STOP2=0, frame 0xA5 -> DATA_VALID one cycle, P_DATA=0xA5, 80 CLK after the start falling edge.
REQ-033 PRESCALE=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA retains previous 0xA5.
REQ-034 PRESCALE=32, STOP2=1, 0x81, second stop bit driven 0 -> STOP_ERR pulse at end of STOP_2, no DATA_VALID.
REQ-035 RX_IN low for 3 CLK, then high (PRESCALE=8) -> glitch rejected, no pulses, next frame 0x55 received correctly.
REQ-036 Single-cycle 1 injected at centre sample of data bit 3 of 0x00 (PRESCALE=16) -> majority vote gives P_DATA=0x00, DATA_VALID.
REQ-037 RST pulsed during DATA of 0xFF -> all outputs 0 immediately; following 0x12 frame -> P_DATA=0x12; with UART_RX_BREAK_DETECT_EN, line held 0 for 12 bit times -> BREAK and STOP_ERR pulse, no new frame until RX_IN returns to 1.

Source files
------------

// File: rtl/uart_rx_gen2.sv
// UART receiver: 3-sample majority per bit, optional parity, one or two stop bits.
// Optional break detection (all-zero frame) when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_gen2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                      BREAK,
`endif
    output logic                      STOP_ERR
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] P1 = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, STOP_2
`ifdef UART_RX_BREAK_DETECT_EN
        , BRK_WAIT
`endif
    } state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] ps_q;
    logic [BCW-1:0]            bit_cnt;
    logic [DATA_WIDTH-1:0]     shreg;
    logic [2:0]                smp;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      stop2_q;
    logic                      par_err_q;
    logic                      stop_err_q;
    logic                      par_bit_q;
    logic                      zero_q;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      maj;
    logic                      bit_end;
    logic                      is_smp;
    logic                      counting;
    logic                      zero_frame;
    logic                      fin_pe;
    logic                      fin_se;

    always_comb begin
        half     = ps_q >> 1;
        maj      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        bit_end  = (edge_cnt == (ps_q - P1));
        is_smp   = (edge_cnt == (half - P1)) || (edge_cnt == half) || (edge_cnt == (half + P1));
        counting = (state == START) || (state == DATA) || (state == PARITY) ||
                   (state == STOP) || (state == STOP_2);
        // Only meaningful while in STOP: data, parity and first stop bit all 0.
        zero_frame = (shreg == '0) && (!par_en_q || !par_bit_q) && !maj;
        // A line-held-low frame is reported as a stop error only, never as parity.
        fin_pe = par_err_q & ~((state == STOP) ? zero_frame : zero_q);
        fin_se = !maj | ((state == STOP_2) & stop_err_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            ps_q       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            smp        <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            par_bit_q  <= 1'b0;
            zero_q     <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STOP_ERR   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK      <= 1'b0;
`endif
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STOP_ERR   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK      <= 1'b0;
`endif
            if (counting) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + P1;
                if (is_smp)
                    smp <= {smp[1:0], RX_IN};
            end

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state      <= START;
                        edge_cnt   <= '0;
                        bit_cnt    <= '0;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        stop2_q    <= STOP2;
                        ps_q       <= PRESCALE;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                        par_bit_q  <= 1'b0;
                        zero_q     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end)
                        state <= maj ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (bit_cnt == BCW'(DATA_WIDTH - 1))
                            state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bit_q <= maj;
                        par_err_q <= (maj != ((^shreg) ^ par_typ_q));
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
`ifdef UART_RX_BREAK_DETECT_EN
                        if (zero_frame) begin
                            BREAK    <= 1'b1;
                            STOP_ERR <= 1'b1;
                            state    <= BRK_WAIT;
                        end else
`endif
                        if (stop2_q) begin
                            stop_err_q <= !maj;
                            zero_q     <= zero_frame;
                            state      <= STOP_2;
                        end else begin
                            if (!fin_pe && !fin_se) begin
                                P_DATA     <= shreg;
                                DATA_VALID <= 1'b1;
                            end else begin
                                PAR_ERR  <= fin_pe;
                                STOP_ERR <= fin_se;
                            end
                            state <= IDLE;
                        end
                    end
                end
                STOP_2: begin
                    if (bit_end) begin
                        if (!fin_pe && !fin_se) begin
                            P_DATA     <= shreg;
                            DATA_VALID <= 1'b1;
                        end else begin
                            PAR_ERR  <= fin_pe;
                            STOP_ERR <= fin_se;
                        end
                        state <= IDLE;
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BRK_WAIT: begin
                    if (RX_IN)
                        state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed bench for uart_rx_gen2: timing, parity, stop, majority, glitch, reset and break cases.
module tb_uart_rx_gen2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STOP_ERR;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       BREAK;
`endif

    int tests = 0;
    int fails = 0;
    int dv_n = 0;
    int pe_n = 0;
    int se_n = 0;
    int brk_n = 0;
    int dv0, pe0, se0, brk0;

    uart_rx_gen2 #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .STOP2(STOP2),
        .PRESCALE(PRESCALE),
        .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR),
`ifdef UART_RX_BREAK_DETECT_EN
        .BREAK(BREAK),
`endif
        .STOP_ERR(STOP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DATA_VALID) dv_n <= dv_n + 1;
        if (PAR_ERR)    pe_n <= pe_n + 1;
        if (STOP_ERR)   se_n <= se_n + 1;
`ifdef UART_RX_BREAK_DETECT_EN
        if (BREAK)      brk_n <= brk_n + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive nbits line bits LSB first, ps cycles each, optionally inverting one cycle.
    task automatic send(input logic [15:0] bits, input int nbits, input int ps, input int glitch);
        for (int j = 0; j < nbits * ps; j++) begin
            RX_IN = bits[j / ps] ^ (j == glitch);
            @(negedge CLK);
        end
        RX_IN = 1'b1;
    endtask

    task automatic snap();
        dv0 = dv_n; pe0 = pe_n; se0 = se_n; brk0 = brk_n;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(DATA_VALID), 32'h0);
        check("rst_pe", 32'(PAR_ERR), 32'h0);
        check("rst_se", 32'(STOP_ERR), 32'h0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("rst_brk", 32'(BREAK), 32'h0);
`endif
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // 0xA5, prescale 8, no parity, one stop: pulse exactly 80 cycles after start detect
        snap();
        send({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 8, -1);
        check("a5_early_dv", 32'(DATA_VALID), 32'h0);
        @(negedge CLK);
        check("a5_dv_pulse", 32'(DATA_VALID), 32'h1);
        check("a5_pdata", 32'(P_DATA), 32'hA5);
        repeat (4) @(negedge CLK);
        check("a5_dv_count", 32'(dv_n - dv0), 32'd1);
        check("a5_err_count", 32'(pe_n - pe0 + se_n - se0), 32'd0);

        // 0x3C, prescale 16, even parity, wrong parity bit 1
        PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 16, -1);
        @(negedge CLK);
        check("par_pe_pulse", 32'(PAR_ERR), 32'h1);
        check("par_dv", 32'(DATA_VALID), 32'h0);
        check("par_pdata_kept", 32'(P_DATA), 32'hA5);
        repeat (4) @(negedge CLK);
        check("par_se_count", 32'(se_n - se0), 32'd0);
        check("par_dv_count", 32'(dv_n - dv0), 32'd0);

        // 0x81, prescale 32, two stops, second stop 0; config changes mid-frame are ignored
        PRESCALE = 6'd32; PAR_EN = 1'b0; STOP2 = 1'b1;
        snap();
        fork
            begin
                repeat (40) @(negedge CLK);
                PAR_EN = 1'b1; STOP2 = 1'b0; PRESCALE = 6'd8;
            end
        join_none
        send({5'b0, 1'b0, 1'b1, 8'h81, 1'b0}, 11, 32, -1);
        @(negedge CLK);
        check("stop2_se_pulse", 32'(STOP_ERR), 32'h1);
        check("stop2_dv", 32'(DATA_VALID), 32'h0);
        repeat (4) @(negedge CLK);
        check("stop2_pe_count", 32'(pe_n - pe0), 32'd0);
        check("stop2_dv_count", 32'(dv_n - dv0), 32'd0);

        // 0x00, prescale 16, one-cycle 1 at centre sample of data bit 3
        PRESCALE = 6'd16; PAR_EN = 1'b0; STOP2 = 1'b0;
        snap();
        send({6'b0, 1'b1, 8'h00, 1'b0}, 10, 16, 4 * 16 + 9);
        @(negedge CLK);
        check("maj_dv_pulse", 32'(DATA_VALID), 32'h1);
        check("maj_pdata", 32'(P_DATA), 32'h00);

        // Three-cycle low glitch at prescale 8, then 0x55
        PRESCALE = 6'd8;
        repeat (4) @(negedge CLK);
        snap();
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        check("glitch_pulses", 32'(dv_n - dv0 + pe_n - pe0 + se_n - se0), 32'd0);
        send({6'b0, 1'b1, 8'h55, 1'b0}, 10, 8, -1);
        @(negedge CLK);
        check("g55_dv_pulse", 32'(DATA_VALID), 32'h1);
        check("g55_pdata", 32'(P_DATA), 32'h55);

        // Asynchronous reset in the middle of the data bits of 0xFF
        PRESCALE = 6'd16;
        repeat (4) @(negedge CLK);
        RX_IN = 1'b0;
        repeat (16) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst_pdata", 32'(P_DATA), 32'h0);
        check("midrst_dv", 32'(DATA_VALID), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        snap();
        repeat (200) @(negedge CLK);
        check("midrst_no_pulse", 32'(dv_n - dv0 + pe_n - pe0 + se_n - se0), 32'd0);
        PRESCALE = 6'd8;
        send({6'b0, 1'b1, 8'h12, 1'b0}, 10, 8, -1);
        @(negedge CLK);
        check("r12_dv_pulse", 32'(DATA_VALID), 32'h1);
        check("r12_pdata", 32'(P_DATA), 32'h12);
        repeat (4) @(negedge CLK);

`ifdef UART_RX_BREAK_DETECT_EN
        // Line low for 12 bit times: one break plus stop error, nothing until line returns high
        snap();
        send(16'h0000, 12, 8, -1);
        repeat (30) @(negedge CLK);
        check("brk_count", 32'(brk_n - brk0), 32'd1);
        check("brk_se_count", 32'(se_n - se0), 32'd1);
        check("brk_pe_count", 32'(pe_n - pe0), 32'd0);
        check("brk_dv_count", 32'(dv_n - dv0), 32'd0);
        send({6'b0, 1'b1, 8'h34, 1'b0}, 10, 8, -1);
        @(negedge CLK);
        check("brk_next_dv", 32'(DATA_VALID), 32'h1);
        check("brk_next_pdata", 32'(P_DATA), 32'h34);
`else
        // All-zero frame at odd parity: stop error only, parity suppressed
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send(16'h0000, 11, 8, -1);
        @(negedge CLK);
        check("zero_se_pulse", 32'(STOP_ERR), 32'h1);
        check("zero_pe", 32'(PAR_ERR), 32'h0);
        repeat (4) @(negedge CLK);
        check("zero_dv_count", 32'(dv_n - dv0), 32'd0);
        check("zero_pdata_kept", 32'(P_DATA), 32'h12);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
